// File: rtl/branch_predict_unit.sv
// Branch prediction unit: direct-mapped BTB with 2-bit counters,
// zero-latency execute-stage resolution and a saturating mispredict count.
module branch_predict_unit #(
  parameter int PC_W    = 9,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  F_PC,
  output logic             Pred_Taken,
  output logic [31:0]      Pred_Target,
  input  logic             Ex_Valid,
  input  logic [PC_W-1:0]  Cur_PC,
  input  logic [31:0]      Imm,
  input  logic             Branch,
  input  logic             Jump,
  input  logic             CurrFlag,
  input  logic [31:0]      AluResult,
  input  logic [31:0]      Reg2,
  input  logic             Ex_PredTaken,
  input  logic [31:0]      Ex_PredTarget,
  output logic [31:0]      PC_Four,
  output logic [31:0]      BrPC,
  output logic             Flush,
  output logic [CNT_W-1:0] Mispredict_Cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  // Tag field must be at least one bit wide.
  if (PC_W < IDX_W + 3) begin : g_bad_pc_w
    $error("branch_predict_unit: PC_W must be >= IDX_W+3");
  end

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [1:0]       ctr;
  } entry_t;

  entry_t tbl [ENTRIES];

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic [IDX_W-1:0] e_idx;
  logic [TAG_W-1:0] e_tag;
  entry_t           f_ent;
  entry_t           e_ent;
  logic             f_hit;
  logic             e_hit;
  logic [31:0]      f_pc4;
  logic [31:0]      e_pc;
  logic             taken;
  logic [31:0]      target;
  logic             wr;
  entry_t           upd;
  logic             unused_bits;

  assign unused_bits = ^AluResult[31:1];

  assign f_idx = F_PC[IDX_W+1:2];
  assign f_tag = F_PC[PC_W-1:IDX_W+2];
  assign e_idx = Cur_PC[IDX_W+1:2];
  assign e_tag = Cur_PC[PC_W-1:IDX_W+2];

  // Fetch lookup: read old contents, fall through to PC+4 on miss.
  always_comb begin
    f_ent       = tbl[f_idx];
    f_hit       = f_ent.valid && (f_ent.tag == f_tag);
    f_pc4       = {{(32-PC_W){1'b0}}, F_PC} + 32'd4;
    Pred_Taken  = f_hit && f_ent.ctr[1];
    Pred_Target = Pred_Taken ? f_ent.target : f_pc4;
  end

  // Execute resolution and mispredict detection, zero latency.
  always_comb begin
    e_pc    = {{(32-PC_W){1'b0}}, Cur_PC};
    PC_Four = e_pc + 32'd4;
    taken   = (Branch && AluResult[0]) || Jump;
    target  = CurrFlag ? (Reg2 + Imm) : (e_pc + Imm);
    BrPC    = taken ? target : PC_Four;
    Flush   = Ex_Valid &&
              ((taken != Ex_PredTaken) ||
               (taken && (target != Ex_PredTarget)));
  end

  // Next value of the entry addressed by the execute PC.
  always_comb begin
    e_ent = tbl[e_idx];
    e_hit = e_ent.valid && (e_ent.tag == e_tag);
    upd   = e_ent;
    wr    = 1'b0;
    if (Ex_Valid) begin
      if (Branch || Jump) begin
        if (e_hit) begin
          wr = 1'b1;
          if (Jump)
            upd.ctr = 2'd3;
          else if (taken)
            upd.ctr = (e_ent.ctr == 2'd3) ? 2'd3 : e_ent.ctr + 2'd1;
          else
            upd.ctr = (e_ent.ctr == 2'd0) ? 2'd0 : e_ent.ctr - 2'd1;
          if (taken)
            upd.target = target;
        end else if (taken) begin
          wr         = 1'b1;
          upd.valid  = 1'b1;
          upd.tag    = e_tag;
          upd.target = target;
          upd.ctr    = Jump ? 2'd3 : 2'd2;
        end
      end else if (Ex_PredTaken && e_hit) begin
        wr        = 1'b1;
        upd.valid = 1'b0;
      end
    end
  end

  // Table write; reset leaves every entry invalid and weakly not-taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: 2'd1};
      end
    end else if (wr) begin
      tbl[e_idx] <= upd;
    end
  end

  // Mispredict count, held at all-ones once full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      Mispredict_Cnt <= '0;
    else if (Flush && (Mispredict_Cnt != {CNT_W{1'b1}}))
      Mispredict_Cnt <= Mispredict_Cnt + 1'b1;
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit.
// Expected values are queued when stimulus is applied and popped at sample time.
module tb_branch_predict_unit;

  logic        clk;
  logic        reset;
  logic [8:0]  F_PC;
  logic        Pred_Taken;
  logic [31:0] Pred_Target;
  logic        Ex_Valid;
  logic [8:0]  Cur_PC;
  logic [31:0] Imm;
  logic        Branch;
  logic        Jump;
  logic        CurrFlag;
  logic [31:0] AluResult;
  logic [31:0] Reg2;
  logic        Ex_PredTaken;
  logic [31:0] Ex_PredTarget;
  logic [31:0] PC_Four;
  logic [31:0] BrPC;
  logic        Flush;
  logic [15:0] Mispredict_Cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  logic [31:0] sb [$];
  logic [31:0] e;

  branch_predict_unit #(.PC_W(9), .ENTRIES(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .F_PC(F_PC),
    .Pred_Taken(Pred_Taken), .Pred_Target(Pred_Target),
    .Ex_Valid(Ex_Valid), .Cur_PC(Cur_PC), .Imm(Imm),
    .Branch(Branch), .Jump(Jump), .CurrFlag(CurrFlag),
    .AluResult(AluResult), .Reg2(Reg2),
    .Ex_PredTaken(Ex_PredTaken), .Ex_PredTarget(Ex_PredTarget),
    .PC_Four(PC_Four), .BrPC(BrPC), .Flush(Flush),
    .Mispredict_Cnt(Mispredict_Cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic br, input logic jp,
                       input logic cf, input logic [8:0] pc,
                       input logic [31:0] imm, input logic [31:0] alu,
                       input logic [31:0] r2, input logic pt,
                       input logic [31:0] ptg);
    Ex_Valid = v; Branch = br; Jump = jp; CurrFlag = cf;
    Cur_PC = pc; Imm = imm; AluResult = alu; Reg2 = r2;
    Ex_PredTaken = pt; Ex_PredTarget = ptg;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 9'h0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    reset = 1'b1; F_PC = 9'h010; idle();
    sb.push_back(32'h0); sb.push_back(32'h14); sb.push_back(32'h0);
    #12;
    e = sb.pop_front(); checks++;
    if (Pred_Taken !== e[0]) begin errors++; $display("FAIL rst_pt got %0h exp %0h", Pred_Taken, e); end
    e = sb.pop_front(); checks++;
    if (Pred_Target !== e) begin errors++; $display("FAIL rst_ptgt got %0h exp %0h", Pred_Target, e); end
    e = sb.pop_front(); checks++;
    if ({16'h0, Mispredict_Cnt} !== e) begin errors++; $display("FAIL rst_cnt got %0h exp %0h", Mispredict_Cnt, e); end
    @(negedge clk); reset = 1'b0;
  endtask

  // Step: apply stimulus at negedge, check comb outputs, clock, check prediction.
  task automatic step(input string nm, input logic [8:0] fpc,
                      input logic exf, input logic [31:0] exbr,
                      input logic exp_pt, input logic [31:0] exp_ptg);
    F_PC = fpc;
    sb.push_back({31'h0, exf}); sb.push_back(exbr);
    if (exf && exp_cnt < 16'hFFFF) exp_cnt++;
    #1;
    e = sb.pop_front(); checks++;
    if (Flush !== e[0]) begin errors++; $display("FAIL %s_flush got %0h exp %0h", nm, Flush, e); end
    e = sb.pop_front(); checks++;
    if (BrPC !== e) begin errors++; $display("FAIL %s_brpc got %0h exp %0h", nm, BrPC, e); end
    sb.push_back({31'h0, exp_pt}); sb.push_back(exp_ptg); sb.push_back(exp_cnt);
    @(posedge clk); #1;
    e = sb.pop_front(); checks++;
    if (Pred_Taken !== e[0]) begin errors++; $display("FAIL %s_pt got %0h exp %0h", nm, Pred_Taken, e); end
    e = sb.pop_front(); checks++;
    if (Pred_Target !== e) begin errors++; $display("FAIL %s_ptgt got %0h exp %0h", nm, Pred_Target, e); end
    e = sb.pop_front(); checks++;
    if ({16'h0, Mispredict_Cnt} !== e) begin errors++; $display("FAIL %s_cnt got %0h exp %0h", nm, Mispredict_Cnt, e); end
    @(negedge clk); idle();
  endtask

  task automatic test_alloc();
    @(negedge clk);
    drive(1, 1, 0, 0, 9'h020, 32'hFFFF_FFF0, 1, 0, 0, 0);
    F_PC = 9'h020;
    sb.push_back(32'h0); sb.push_back(32'h24);
    #1;
    e = sb.pop_front(); checks++;
    if (Pred_Taken !== e[0]) begin errors++; $display("FAIL same_cyc_pt got %0h exp %0h", Pred_Taken, e); end
    e = sb.pop_front(); checks++;
    if (PC_Four !== e) begin errors++; $display("FAIL pc_four got %0h exp %0h", PC_Four, e); end
    step("alloc", 9'h020, 1, 32'h10, 1, 32'h10);
    F_PC = 9'h120;
    sb.push_back(32'h0); sb.push_back(32'h124);
    #1;
    e = sb.pop_front(); checks++;
    if (Pred_Taken !== e[0]) begin errors++; $display("FAIL alias_pt got %0h exp %0h", Pred_Taken, e); end
    e = sb.pop_front(); checks++;
    if (Pred_Target !== e) begin errors++; $display("FAIL alias_ptgt got %0h exp %0h", Pred_Target, e); end
  endtask

  task automatic test_counter();
    drive(1, 1, 0, 0, 9'h020, 32'hFFFF_FFF0, 0, 0, 1, 32'h10);
    step("nt1", 9'h020, 1, 32'h24, 0, 32'h24);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 9'h020, 32'hFFFF_FFF0, 0, 0, 0, 0);
      step("ntsat", 9'h020, 0, 32'h24, 0, 32'h24);
    end
    drive(1, 1, 0, 0, 9'h020, 32'hFFFF_FFF0, 1, 0, 0, 0);
    step("tk_from0", 9'h020, 1, 32'h10, 0, 32'h24);
    drive(1, 1, 0, 0, 9'h020, 32'hFFFF_FFF0, 1, 0, 0, 0);
    step("tk_to2", 9'h020, 1, 32'h10, 1, 32'h10);
    drive(1, 1, 0, 0, 9'h020, 32'hFFFF_FFF0, 1, 0, 1, 32'h10);
    step("correct", 9'h020, 0, 32'h10, 1, 32'h10);
    drive(1, 1, 0, 0, 9'h020, 32'hFFFF_FFF0, 1, 0, 1, 32'h14);
    step("badtgt", 9'h020, 1, 32'h10, 1, 32'h10);
  endtask

  task automatic test_jump();
    drive(1, 0, 1, 1, 9'h040, 32'h8, 0, 32'h100, 1, 32'h104);
    step("jalr", 9'h040, 1, 32'h108, 1, 32'h108);
    drive(1, 1, 0, 0, 9'h040, 32'h8, 0, 0, 1, 32'h108);
    step("j_dec1", 9'h040, 1, 32'h44, 1, 32'h108);
    drive(1, 1, 0, 0, 9'h040, 32'h8, 0, 0, 1, 32'h108);
    step("j_dec2", 9'h040, 1, 32'h44, 0, 32'h44);
    drive(1, 1, 1, 0, 9'h040, 32'h20, 0, 0, 0, 0);
    step("br_jmp", 9'h040, 1, 32'h60, 1, 32'h60);
  endtask

  task automatic test_bubble();
    drive(0, 1, 0, 0, 9'h080, 32'h10, 1, 0, 0, 0);
    step("bubble", 9'h080, 0, 32'h90, 0, 32'h84);
  endtask

  task automatic test_invalidate();
    drive(1, 0, 0, 0, 9'h020, 32'h0, 0, 0, 1, 32'h10);
    F_PC = 9'h020;
    sb.push_back(32'h1);
    #1;
    e = sb.pop_front(); checks++;
    if (Pred_Taken !== e[0]) begin errors++; $display("FAIL inv_pre_pt got %0h exp %0h", Pred_Taken, e); end
    step("inval", 9'h020, 1, 32'h24, 0, 32'h24);
  endtask

  task automatic test_saturate();
    drive(1, 0, 0, 0, 9'h0C0, 32'h0, 0, 0, 1, 0);
    F_PC = 9'h040;
    repeat (65541) @(posedge clk);
    @(negedge clk);
    sb.push_back(32'hFFFF); sb.push_back(32'h1);
    #1;
    e = sb.pop_front(); checks++;
    if ({16'h0, Mispredict_Cnt} !== e) begin errors++; $display("FAIL sat_cnt got %0h exp %0h", Mispredict_Cnt, e); end
    e = sb.pop_front(); checks++;
    if (Pred_Taken !== e[0]) begin errors++; $display("FAIL pre_rst_pt got %0h exp %0h", Pred_Taken, e); end
    #1 reset = 1'b1;
    sb.push_back(32'h0); sb.push_back(32'h0); sb.push_back(32'h44);
    sb.push_back(32'h1); sb.push_back(32'hC4);
    #1;
    e = sb.pop_front(); checks++;
    if ({16'h0, Mispredict_Cnt} !== e) begin errors++; $display("FAIL async_rst_cnt got %0h exp %0h", Mispredict_Cnt, e); end
    e = sb.pop_front(); checks++;
    if (Pred_Taken !== e[0]) begin errors++; $display("FAIL async_rst_pt got %0h exp %0h", Pred_Taken, e); end
    e = sb.pop_front(); checks++;
    if (Pred_Target !== e) begin errors++; $display("FAIL async_rst_ptgt got %0h exp %0h", Pred_Target, e); end
    e = sb.pop_front(); checks++;
    if (Flush !== e[0]) begin errors++; $display("FAIL rst_flush got %0h exp %0h", Flush, e); end
    e = sb.pop_front(); checks++;
    if (BrPC !== e) begin errors++; $display("FAIL rst_brpc got %0h exp %0h", BrPC, e); end
    @(posedge clk); #1;
    sb.push_back(32'h0);
    e = sb.pop_front(); checks++;
    if ({16'h0, Mispredict_Cnt} !== e) begin errors++; $display("FAIL rst_hold_cnt got %0h exp %0h", Mispredict_Cnt, e); end
    @(negedge clk); idle(); reset = 1'b0;
    F_PC = 9'h020;
    sb.push_back(32'h0); sb.push_back(32'h24);
    #1;
    e = sb.pop_front(); checks++;
    if (Pred_Taken !== e[0]) begin errors++; $display("FAIL post_rst_pt got %0h exp %0h", Pred_Taken, e); end
    e = sb.pop_front(); checks++;
    if (Pred_Target !== e) begin errors++; $display("FAIL post_rst_ptgt got %0h exp %0h", Pred_Target, e); end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_counter();
    test_jump();
    test_bubble();
    test_invalidate();
    test_saturate();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameters, one per line:
- PC_W, default 9, instruction-address width.
- ENTRIES, default 16, predictor table depth, power of two.
- CNT_W, default 16, mispredict counter width.
REQ-002 IDX_W = log2(ENTRIES); the block SHALL require PC_W >= IDX_W+3.
REQ-003 Ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- F_PC  in  PC_W  fetch-stage PC to look up.
- Pred_Taken  out  1  fetch prediction: taken.
- Pred_Target  out  32  fetch next-PC prediction.
- Ex_Valid  in  1  execute stage holds a real instruction; 0 is a bubble.
- Cur_PC  in  PC_W  execute-stage PC.
- Imm  in  32  branch/jump offset.
- Branch  in  1  conditional branch in execute.
- Jump  in  1  unconditional jump in execute.
- CurrFlag  in  1  1 means JALR-style base Reg2; 0 means base Cur_PC.
- AluResult  in  32  bit 0 is the branch condition.
- Reg2  in  32  JALR base register.
- Ex_PredTaken  in  1  prediction carried with the execute instruction.
- Ex_PredTarget  in  32  predicted target carried with the execute instruction.
- PC_Four  out  32  Cur_PC+4, zero-extended.
- BrPC  out  32  corrected next PC.
- Flush  out  1  mispredict; pipeline must redirect to BrPC.
- Mispredict_Cnt  out  CNT_W  saturating mispredict count.

Function
REQ-004 Table: ENTRIES entries, each holding valid, tag (PC_W-IDX_W-2 bits), 32-bit target, and a 2-bit saturating counter; index = PC[IDX_W+1:2], tag = PC[PC_W-1:IDX_W+2].
REQ-005 Lookup is combinational: hit = valid[idx(F_PC)] && tag match; Pred_Taken = hit && ctr[1]; Pred_Target = Pred_Taken ? stored target : zero-extended F_PC+4.
REQ-006 Resolution (combinational):
- Taken = (Branch && AluResult[0]) || Jump.
- Target = CurrFlag ? Reg2+Imm : {0,Cur_PC}+Imm, modulo 2^32.
- BrPC = Taken ? Target : PC_Four.
REQ-007 Flush = Ex_Valid && (Taken != Ex_PredTaken || (Taken && Target != Ex_PredTarget)); this covers a predicted-taken non-branch (Branch=Jump=0), which flushes to PC_Four.
REQ-008 Flush and BrPC SHALL be valid in the same cycle as the execute inputs (zero latency); Flush is asserted only while its condition holds.
REQ-009 Update at the rising edge, only when Ex_Valid=1; the entry is addressed by Cur_PC:
- Branch or Jump, hit: counter +1 if Taken (saturate at 3), -1 if not (saturate at 0); target written when Taken; Jump forces counter to 3.
- Branch or Jump, miss, Taken: allocate (valid=1, tag, target, counter=2, or 3 if Jump).
- Branch or Jump, miss, not taken: no change.
- Branch=Jump=0 with Ex_PredTaken=1 and hit: invalidate the entry.
REQ-010 Lookup and update at the same index in the same cycle: lookup returns the pre-update contents; the new value is visible the next cycle.
REQ-011 Branch and Jump both high is treated as Jump.
REQ-012 Mispredict_Cnt increments on each edge where Flush=1 and saturates at all-ones (no wrap).
REQ-013 Ex_Valid=0: Flush=0, no table or counter change; BrPC and PC_Four are still computed.

Reset
REQ-014 Reset asserted SHALL asynchronously clear all valid bits, set all counters to 1 (weakly not-taken), clear targets and tags, and clear Mispredict_Cnt to 0.
REQ-015 During and after reset, Pred_Taken=0 and Pred_Target=F_PC+4.
REQ-016 Reset asserted mid-operation discards any pending update at that edge.
REQ-017 Reset has no effect on combinational resolution outputs beyond table contents.

Verification
REQ-018 All scenarios use ENTRIES=16, PC_W=9.
- After reset, F_PC=0x010 -> Pred_Taken=0, Pred_Target=0x014, Mispredict_Cnt=0.
- Ex_Valid=1, Branch=1, Cur_PC=0x020, Imm=0xFFFFFFF0, AluResult=1, Ex_PredTaken=0 -> Flush=1, BrPC=0x010 that cycle; next cycle F_PC=0x020 -> Pred_Taken=1, Pred_Target=0x010, Mispredict_Cnt=1.
- Same branch resolved not-taken once -> counter 2->1, F_PC=0x020 gives Pred_Taken=0; three more not-taken -> counter stays 0.
- Jump=1, CurrFlag=1, Reg2=0x100, Imm=8, Ex_PredTaken=1, Ex_PredTarget=0x104 -> Flush=1, BrPC=0x108, entry counter=3.
- Entry at 0x020 valid and taken; Branch=Jump=0, Cur_PC=0x020, Ex_PredTaken=1 -> Flush=1, BrPC=0x024; next cycle lookup at 0x020 misses.
- Hold Flush condition for 2^16+5 cycles -> Mispredict_Cnt=0xFFFF; assert reset mid-run -> count 0 and all lookups miss immediately.
